conv_sequencer: RTL and testbench

- Control-side initiator for the signed 8-bit convolve MAC datapath.
- Walks a 2D feature map stored in an external image memory with a KxK kernel. Valid padding, stride 1.
- For each window: fetches pixel and weight bytes, drives the MAC control strobes (clken, s_convout, en_mult_r, en_sat), then captures the saturated 8-bit convout into an output memory.
- Sits between the image/weight/output RAMs and one convolve instance.

---
 rtl/conv_sequencer.sv | 151 +++++++++++++++
 tb/tb_conv_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer: walks an image with a KxK kernel (valid, stride 1), driving the convolve MAC strobes and writing each result.
// Optional ReLU on written outputs is enabled by defining CONV_SEQUENCER_RELU_EN.
module conv_sequencer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K = 3,
  parameter int MAC_LAT = 2,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_rdata,
  output logic [AW-1:0] wgt_addr,
  input  logic [7:0]    wgt_rdata,
  output logic [7:0]    signal,
  output logic [7:0]    weight,
  output logic          clken,
  output logic          s_convout,
  output logic          en_mult_r,
  output logic          en_sat,
  input  logic [7:0]    convout,
  output logic          out_we,
  output logic [AW-1:0] out_addr,
  output logic [7:0]    out_data
);
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int KW = K > 1 ? $clog2(K) : 1;
  localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;
  localparam int RW = OUT_H > 1 ? $clog2(OUT_H) : 1;
  localparam int DW = MAC_LAT > 0 ? $clog2(MAC_LAT + 1) : 1;

  typedef enum logic [2:0] {IDLE, TAP, DRAIN, SAT, WRITE, FIN} state_t;

  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [KW-1:0] ky_q, ky_d, kx_q, kx_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [AW-1:0] img_addr_q, img_addr_d, wgt_addr_q, wgt_addr_d;
  logic          clken_q, clken_d, s_convout_q, s_convout_d;
  logic [7:0]    wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      dcnt_q      <= '0;
      img_addr_q  <= '0;
      wgt_addr_q  <= '0;
      clken_q     <= 1'b0;
      s_convout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      dcnt_q      <= dcnt_d;
      img_addr_q  <= img_addr_d;
      wgt_addr_q  <= wgt_addr_d;
      clken_q     <= clken_d;
      s_convout_q <= s_convout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = TAP;
        row_d   = '0;
        col_d   = '0;
        ky_d    = '0;
        kx_d    = '0;
      end
      TAP: if (kx_q == KW'(K - 1)) begin
        kx_d = '0;
        if (ky_q == KW'(K - 1)) begin
          ky_d    = '0;
          dcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          ky_d = ky_q + 1'b1;
        end
      end else begin
        kx_d = kx_q + 1'b1;
      end
      DRAIN: if (dcnt_q == DW'(MAC_LAT)) state_d = SAT;
             else dcnt_d = dcnt_q + 1'b1;
      SAT: state_d = WRITE;
      WRITE: if (col_q == CW'(OUT_W - 1)) begin
        col_d = '0;
        if (row_q == RW'(OUT_H - 1)) begin
          row_d   = '0;
          state_d = FIN;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = TAP;
        end
      end else begin
        col_d   = col_q + 1'b1;
        state_d = TAP;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are registered from next-state counters so they appear on the tap cycle itself and hold afterwards.
  always_comb begin
    img_addr_d  = state_d == TAP ? AW'((int'(row_d) + int'(ky_d)) * IMG_W + int'(col_d) + int'(kx_d)) : img_addr_q;
    wgt_addr_d  = state_d == TAP ? AW'(int'(ky_d) * K + int'(kx_d)) : wgt_addr_q;
    clken_d     = state_q == TAP;
    s_convout_d = state_q == TAP && ky_q == '0 && kx_q == '0;
  end

`ifdef CONV_SEQUENCER_RELU_EN
  assign wr_data = convout[7] ? 8'h00 : convout;
`else
  assign wr_data = convout;
`endif

  always_comb begin
    busy      = state_q == TAP || state_q == DRAIN || state_q == SAT || state_q == WRITE;
    done      = state_q == FIN;
    img_addr  = img_addr_q;
    wgt_addr  = wgt_addr_q;
    signal    = img_rdata;
    weight    = wgt_rdata;
    clken     = clken_q;
    s_convout = s_convout_q;
    en_mult_r = clken_q || state_q == DRAIN || state_q == SAT || state_q == WRITE;
    en_sat    = state_q == SAT || state_q == WRITE;
    out_we    = state_q == WRITE;
    out_addr  = state_q == WRITE ? AW'(int'(row_q) * OUT_W + int'(col_q)) : '0;
    out_data  = state_q == WRITE ? wr_data : 8'h00;
  end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed bench for conv_sequencer on a 4x4 image, K=3, MAC_LAT=2.
module tb_conv_sequencer;
  localparam int AW = 16;
  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, clken, s_convout, en_mult_r, en_sat, out_we;
  logic [AW-1:0] img_addr, wgt_addr, out_addr;
  logic [7:0]    img_rdata = 8'h00, wgt_rdata = 8'h00, signal, weight, convout, out_data;
  int            n_tests = 0, n_fail = 0;

  conv_sequencer #(.IMG_W(4), .IMG_H(4), .K(3), .MAC_LAT(2), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .img_addr(img_addr), .img_rdata(img_rdata), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
    .signal(signal), .weight(weight), .clken(clken), .s_convout(s_convout),
    .en_mult_r(en_mult_r), .en_sat(en_sat), .convout(convout),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    img_rdata <= img_addr[7:0];
    wgt_rdata <= wgt_addr[7:0] + 8'd16;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({busy, done, clken, s_convout, en_mult_r, en_sat, out_we});
  endfunction

  task automatic check_quiet(input string tag);
    chk(tag, strobes(), 32'd0);
  endtask

  task automatic run(input logic [7:0] cv, input logic [7:0] exp_data, input bit extra, input int abort_at);
    int w, o, t;
    bit in_run;
    convout = cv;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 61; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        check_quiet("abort_strobes");
        chk("abort_addrs", 32'({img_addr, wgt_addr}), 32'd0);
        chk("abort_out", 32'({out_addr, out_data}), 32'd0);
        repeat (2) begin
          @(negedge clk);
          check_quiet("abort_hold");
        end
        reset = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check_quiet("abort_idle");
        end
        return;
      end
      w = c / 14;
      o = c % 14;
      in_run = c < 56;
      chk("strobes", strobes(), 32'({in_run, c == 56, in_run && o >= 1 && o <= 9, in_run && o == 1,
                                      in_run && o >= 1 && o <= 13, in_run && o >= 12, in_run && o == 13}));
      if (in_run && o <= 8) begin
        chk("img_addr", 32'(img_addr), 32'((w / 2 + o / 3) * 4 + w % 2 + o % 3));
        chk("wgt_addr", 32'(wgt_addr), 32'(o));
      end
      if (in_run && o >= 1 && o <= 9) begin
        t = o - 1;
        chk("signal", 32'(signal), 32'((w / 2 + t / 3) * 4 + w % 2 + t % 3));
        chk("weight", 32'(weight), 32'(t + 16));
      end
      if (in_run && o == 13) begin
        chk("out_addr", 32'(out_addr), 32'(w));
        chk("out_data", 32'(out_data), 32'(exp_data));
      end
      start = extra && (c == 5 || c == 20 || c == 41);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] neg_exp;
`ifdef CONV_SEQUENCER_RELU_EN
    neg_exp = 8'h00;
`else
    neg_exp = 8'hFB;
`endif
    reset = 1'b0;
    start = 1'b1;
    convout = 8'h00;
    repeat (3) @(negedge clk);
    check_quiet("rst_strobes");
    chk("rst_addrs", 32'({img_addr, wgt_addr}), 32'd0);
    chk("rst_out", 32'({out_addr, out_data}), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_quiet("idle_after_rst");
    end
    run(8'hFB, neg_exp, 1'b0, -1);
    run(8'h7F, 8'h7F, 1'b1, -1);
    run(8'h12, 8'h12, 1'b0, 31);
    run(8'hFB, neg_exp, 1'b1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
